// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the MIPS DataPath and a
// byte-wide synchronous SRAM.
//
// Handshake: the DataPath raises MOV with RW/OpC/MAR/DataIn and holds it.
// The request is taken on the first rising edge where the block is in IDLE.
// The block then ignores all request inputs until MOV has dropped back to 0
// after the single-cycle MOC pulse.
//
// Transfers are big-endian, one byte per cycle, MSB first. The byte address
// wraps modulo 2**ADDR_W. Load data is returned one cycle after each mem_re
// cycle. DataOut is written only when a load completes.
//
// Optional build macro MEM_ALIGN_CHECK_EN: a misaligned halfword or word
// request completes at once with addr_err=1 and makes no SRAM access.
// Without the macro, addr_err is tied 0.
module mem_access_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [5:0]        OpC,
    input  logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MOC,
    output logic              busy,
    output logic              addr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XFER = 3'd1,
        LAST = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  idx;          // byte index within the current transfer
    logic [1:0]  last_idx;     // N-1 for the latched request
    logic        is_read;
    logic        is_unsigned;
    logic [31:0] wsh;          // store bytes still to send, next one in [31:24]
    logic [23:0] acc;          // load bytes already returned, oldest highest
    logic        rd_valid;     // mem_rdata carries a requested byte this cycle

    logic [1:0]  req_last;
    logic [31:0] req_wdata;
    logic [31:0] load_full;
    logic [31:0] load_result;

    assign state_dbg = state;

    // Decode the transfer length (as last byte index) from the full opcode.
    always_comb begin
        req_last = 2'd3;
        case (OpC)
            6'b100000, 6'b100100, 6'b101000: req_last = 2'd0;
            6'b100001, 6'b100101, 6'b101001: req_last = 2'd1;
            default:                         req_last = 2'd3;
        endcase
    end

    // Left-align the store data so the first byte to send sits in [31:24].
    always_comb begin
        req_wdata = DataIn;
        case (req_last)
            2'd0:    req_wdata = {DataIn[7:0], 24'h000000};
            2'd1:    req_wdata = {DataIn[15:0], 16'h0000};
            default: req_wdata = DataIn;
        endcase
    end

    // Assemble the final load word from the accumulated and current bytes.
    always_comb begin
        load_full   = {acc, mem_rdata};
        load_result = load_full;
        case (last_idx)
            2'd0: load_result = is_unsigned ? {24'h000000, load_full[7:0]}
                                            : {{24{load_full[7]}}, load_full[7:0]};
            2'd1: load_result = is_unsigned ? {16'h0000, load_full[15:0]}
                                            : {{16{load_full[15]}}, load_full[15:0]};
            default: load_result = load_full;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic req_misaligned;

    // A halfword must be even-aligned; a word must be 4-byte aligned.
    always_comb begin
        req_misaligned = 1'b0;
        if (req_last == 2'd1 && MAR[0])
            req_misaligned = 1'b1;
        else if (req_last == 2'd3 && MAR[1:0] != 2'b00)
            req_misaligned = 1'b1;
    end
`else
    assign addr_err = 1'b0;
`endif

    // Transfer FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            last_idx    <= 2'd0;
            is_read     <= 1'b0;
            is_unsigned <= 1'b0;
            wsh         <= 32'h0;
            acc         <= 24'h0;
            rd_valid    <= 1'b0;
            DataOut     <= '0;
            MOC         <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_wdata   <= 8'h00;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else begin
            MOC      <= 1'b0;
            rd_valid <= mem_re;
            if (rd_valid)
                acc <= {acc[15:0], mem_rdata};

            case (state)
                IDLE: begin
                    if (MOV) begin
                        is_read     <= RW;
                        is_unsigned <= OpC[2];
                        last_idx    <= req_last;
                        idx         <= 2'd0;
                        acc         <= 24'h0;
                        busy        <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                        if (req_misaligned) begin
                            state    <= DONE;
                            MOC      <= 1'b1;
                            addr_err <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state     <= XFER;
                            mem_addr  <= MAR;
                            mem_re    <= RW;
                            mem_we    <= !RW;
                            mem_wdata <= req_wdata[31:24];
                            wsh       <= {req_wdata[23:0], 8'h00};
                        end
                    end
                end

                XFER: begin
                    if (idx == last_idx) begin
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        if (is_read) begin
                            state <= LAST;
                        end else begin
                            state <= DONE;
                            MOC   <= 1'b1;
                        end
                    end else begin
                        idx       <= idx + 2'd1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= wsh[31:24];
                        wsh       <= {wsh[23:0], 8'h00};
                    end
                end

                LAST: begin
                    DataOut <= load_result;
                    MOC     <= 1'b1;
                    state   <= DONE;
                end

                DONE: begin
                    state <= HOLD;
                end

                HOLD: begin
                    if (!MOV) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        addr_err <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases followed by random load/store
// traffic. The expected results come from a byte-array memory model.
module tb_mem_access_ctrl;

    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MOV = 1'b0;
    logic          RW = 1'b0;
    logic [5:0]    OpC = 6'd0;
    logic [AW-1:0] MAR = '0;
    logic [31:0]   DataIn = 32'h0;
    logic [31:0]   DataOut;
    logic          MOC;
    logic          busy;
    logic          addr_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic [2:0]    state_dbg;

    logic [7:0]    sram    [DEPTH];
    logic [7:0]    ref_mem [DEPTH];
    logic [31:0]   last_dout;
    int            checks = 0;
    int            errors = 0;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .OpC(OpC), .MAR(MAR),
        .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC), .busy(busy),
        .addr_err(addr_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Synchronous byte-wide SRAM attached to the controller.
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [5:0] opc);
        case (opc)
            6'b100000, 6'b100100, 6'b101000: return 1;
            6'b100001, 6'b100101, 6'b101001: return 2;
            default:                         return 4;
        endcase
    endfunction

    // Expected load value: read N bytes big-endian, then extend per opcode.
    function automatic logic [31:0] model_load(input logic [5:0] opc, input logic [AW-1:0] mar);
        int n;
        logic [31:0] v;
        n = size_of(opc);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = (v << 8) | {24'h0, ref_mem[(int'(mar) + i) % DEPTH]};
        if (!opc[2]) begin
            if (n == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (n == 2 && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // Issue one request, hold MOV for 'hold' cycles past MOC, then release it.
    task automatic do_op(input string tag, input logic rw, input logic [5:0] opc,
                         input logic [AW-1:0] mar, input logic [31:0] din, input int hold);
        int n, lat, moc_cnt, we_cnt, re_cnt, both;
        logic [31:0] exp_dout, dout_at_moc;
        bit idle_seen;
        n = size_of(opc);
        exp_dout = rw ? model_load(opc, mar) : last_dout;
        lat = -1; moc_cnt = 0; we_cnt = 0; re_cnt = 0; both = 0;
        dout_at_moc = 'x;
        idle_seen = 1'b0;
        @(negedge clk);
        MOV = 1'b1; RW = rw; OpC = opc; MAR = mar; DataIn = din;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if (mem_we && mem_re) both++;
            if (MOC) begin
                moc_cnt++;
                if (lat < 0) begin
                    lat = k;
                    dout_at_moc = DataOut;
                end
            end
            if (k == 0) begin
                RW = 1'($urandom_range(0, 1));
                OpC = 6'($urandom);
                MAR = AW'($urandom);
                DataIn = $urandom;
            end
            if (lat >= 0 && k >= lat + hold) break;
        end
        MOV = 1'b0;
        for (int j = 0; j < 10 && !idle_seen; j++) begin
            @(posedge clk); #1;
            if (MOC) moc_cnt++;
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if (!busy) idle_seen = 1'b1;
        end
        if (!rw) begin
            for (int i = 0; i < n; i++)
                ref_mem[(int'(mar) + i) % DEPTH] = 8'(din >> (8 * (n - 1 - i)));
        end else begin
            last_dout = exp_dout;
        end
        chk({tag, "_latency"}, lat, rw ? n + 1 : n);
        chk({tag, "_moc_count"}, moc_cnt, 1);
        chk({tag, "_we_count"}, we_cnt, rw ? 0 : n);
        chk({tag, "_re_count"}, re_cnt, rw ? n : 0);
        chk({tag, "_we_re_overlap"}, both, 0);
        chk({tag, "_dataout"}, dout_at_moc, exp_dout);
        chk({tag, "_idle"}, {31'h0, idle_seen}, 32'h1);
        chk({tag, "_strobes_idle"}, {30'h0, mem_we, mem_re}, 32'h0);
    endtask

    logic [5:0] opcs [10];
    logic [31:0] rst_din;
    int moc_after_rst;

    initial begin
        opcs = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                 6'b101000, 6'b101001, 6'b101011, 6'b100010, 6'b000000};
        for (int i = 0; i < DEPTH; i++) begin
            sram[i] = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        last_dout = 32'h0;

        // Reset state.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dataout", DataOut, 32'h0);
        chk("reset_ctrl", {28'h0, MOC, busy, mem_we, mem_re}, 32'h0);
        chk("reset_addr", {23'h0, mem_addr}, 32'h0);
        chk("reset_wdata", {24'h0, mem_wdata}, 32'h0);
        chk("reset_addr_err", {31'h0, addr_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Store then load a word.
        do_op("sw_dead", 1'b0, 6'b101011, 9'd16, 32'hDEADBEEF, 1);
        chk("sw_dead_b16", {24'h0, sram[16]}, 32'hDE);
        chk("sw_dead_b17", {24'h0, sram[17]}, 32'hAD);
        chk("sw_dead_b18", {24'h0, sram[18]}, 32'hBE);
        chk("sw_dead_b19", {24'h0, sram[19]}, 32'hEF);
        do_op("lw_dead", 1'b1, 6'b100011, 9'd16, 32'h0, 1);
        chk("lw_dead_value", DataOut, 32'hDEADBEEF);

        // Reset in the middle of a word store: only the first byte lands.
        rst_din = $urandom;
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; OpC = 6'b101011; MAR = 9'd8; DataIn = rst_din;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_dataout", DataOut, 32'h0);
        chk("midrst_ctrl", {28'h0, MOC, busy, mem_we, mem_re}, 32'h0);
        chk("midrst_addr", {23'h0, mem_addr}, 32'h0);
        chk("midrst_wdata", {24'h0, mem_wdata}, 32'h0);
        chk("midrst_state", {29'h0, state_dbg}, 32'h0);
        ref_mem[8] = rst_din[31:24];
        last_dout = 32'h0;
        MOV = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        moc_after_rst = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (MOC || busy) moc_after_rst++;
        end
        chk("midrst_no_moc", moc_after_rst, 0);
        do_op("lw_after_rst", 1'b1, 6'b100011, 9'd8, 32'h0, 1);

        // Sign and zero extension.
        do_op("sb_80", 1'b0, 6'b101000, 9'd32, 32'h12345680, 1);
        do_op("lb_80", 1'b1, 6'b100000, 9'd32, 32'h0, 1);
        chk("lb_80_value", DataOut, 32'hFFFFFF80);
        do_op("lbu_80", 1'b1, 6'b100100, 9'd32, 32'h0, 1);
        chk("lbu_80_value", DataOut, 32'h00000080);
        do_op("sh_9abc", 1'b0, 6'b101001, 9'd40, 32'h55559ABC, 1);
        do_op("lh_9abc", 1'b1, 6'b100001, 9'd40, 32'h0, 1);
        chk("lh_9abc_value", DataOut, 32'hFFFF9ABC);
        do_op("lhu_9abc", 1'b1, 6'b100101, 9'd40, 32'h0, 1);
        chk("lhu_9abc_value", DataOut, 32'h00009ABC);

        // Address wrap at the top of memory.
        do_op("sw_wrap", 1'b0, 6'b101011, 9'd510, 32'h11223344, 1);
        chk("wrap_b510", {24'h0, sram[510]}, 32'h11);
        chk("wrap_b511", {24'h0, sram[511]}, 32'h22);
        chk("wrap_b0", {24'h0, sram[0]}, 32'h33);
        chk("wrap_b1", {24'h0, sram[1]}, 32'h44);
        do_op("lw_wrap", 1'b1, 6'b100011, 9'd510, 32'h0, 1);
        chk("lw_wrap_value", DataOut, 32'h11223344);

        // MOV held long after completion: exactly one execution.
        do_op("sb_hold", 1'b0, 6'b101000, 9'd100, $urandom, 10);
        do_op("lw_hold", 1'b1, 6'b100011, 9'd98, 32'h0, 7);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            do_op($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                  opcs[$urandom_range(0, 9)], AW'($urandom), $urandom,
                  $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
